// File: rtl/led_disp_pkg.sv
// Shared constants, state encoding and PWM helper for the multiplexed 7-seg scan controller.
package led_disp_pkg;

    localparam logic [2:0] SEL_OFF   = 3'b111;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DIGIT_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_t;

    // Number of DRIVE cycles lit for a brightness code: ((bright+1)*drive_len)/16.
    function automatic int pwm_limit(input int bright, input int drive_len);
        return ((bright + 1) * drive_len) >> 4;
    endfunction

endpackage

// File: rtl/led_slot_timer.sv
// Per-digit slot counter: counts 0..CLK_DIV-1 and flags the end of dead-time and of the slot.
module led_slot_timer #(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       clear,
    input  logic                       run,
    output logic                       dead_done,
    output logic                       slot_done,
    output logic [$clog2(CLK_DIV)-1:0] offset
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] slot_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            slot_cnt <= '0;
        end else if (clear) begin
            slot_cnt <= '0;
        end else if (run) begin
            slot_cnt <= slot_done ? '0 : slot_cnt + 1'b1;
        end
    end

    assign dead_done = (slot_cnt == CW'(DEAD_CYCLES - 1));
    assign slot_done = (slot_cnt == CW'(CLK_DIV - 1));
    assign offset    = slot_cnt - CW'(DEAD_CYCLES);

endmodule

// File: rtl/led_scan_ctrl.sv
// 4-digit 7-seg scan scheduler with dead-time, frame-aligned double buffering and update handshake.
// Optional brightness PWM when LED_SCAN_PWM_EN is defined.
module led_scan_ctrl
    import led_disp_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 16,
    parameter int NUM_DIGITS  = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        en,
    input  logic        upd_req,
    input  logic [31:0] data_in,
    output logic        upd_ack,
    output logic [2:0]  sel,
    output logic [7:0]  data1,
    output logic [7:0]  data10,
    output logic [7:0]  data100,
    output logic [7:0]  data1000,
    output logic        frame_start
`ifdef LED_SCAN_PWM_EN
    ,
    input  logic [3:0]  bright
`endif
);

    localparam int                   CW         = $clog2(CLK_DIV);
    localparam int                   DRIVE_LEN  = CLK_DIV - DEAD_CYCLES;
    localparam logic [DIGIT_W-1:0]   LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

    scan_state_t         state, state_next;
    logic [DIGIT_W-1:0]  digit;
    logic [31:0]         shadow;
    logic                armed;
    logic                dead_done, slot_done;
    logic [CW-1:0]       offset;
    logic [CW-1:0]       thr;
    logic                boundary, capture, pwm_on;

    led_slot_timer #(
        .CLK_DIV     (CLK_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_slot_timer (
        .clk       (clk),
        .clr_n     (clr_n),
        .clear     (~en),
        .run       (state != IDLE),
        .dead_done (dead_done),
        .slot_done (slot_done),
        .offset    (offset)
    );

    // The edge that starts digit 0 of a new frame; shadows may only change here (or while dark).
    assign boundary = en & ((state == IDLE) |
                            ((state == DRIVE) & slot_done & (digit == LAST_DIGIT)));
    assign capture  = upd_req & armed & (boundary | ~en);

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (en) state_next = BLANK;
            BLANK:   if (!en) state_next = IDLE;
                     else if (dead_done) state_next = DRIVE;
            DRIVE:   if (!en) state_next = IDLE;
                     else if (slot_done) state_next = BLANK;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= IDLE;
            digit       <= '0;
            shadow      <= {4{SEG_BLANK}};
            armed       <= 1'b1;
            upd_ack     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            upd_ack     <= capture;
            frame_start <= boundary;
            if (!en) begin
                digit <= '0;
            end else if ((state == DRIVE) && slot_done) begin
                digit <= (digit == LAST_DIGIT) ? '0 : digit + 1'b1;
            end
            if (capture) begin
                shadow <= data_in;
            end
            // A held request is spent once acked; it re-arms only after upd_req drops.
            if (capture) begin
                armed <= 1'b0;
            end else if (!upd_req) begin
                armed <= 1'b1;
            end
        end
    end

`ifdef LED_SCAN_PWM_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            thr <= CW'(DRIVE_LEN);
        end else if (en && ((state == IDLE) || ((state == DRIVE) && slot_done))) begin
            thr <= CW'(pwm_limit(int'(bright), DRIVE_LEN));
        end
    end
`else
    assign thr = CW'(DRIVE_LEN);
`endif

    assign pwm_on = (offset < thr);

    always_comb begin
        sel = SEL_OFF;
        if ((state == DRIVE) && pwm_on) begin
            sel = {1'b0, digit};
        end
    end

    assign data1    = shadow[7:0];
    assign data10   = shadow[15:8];
    assign data100  = shadow[23:16];
    assign data1000 = shadow[31:24];

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with CLK_DIV=20, DEAD_CYCLES=4, NUM_DIGITS=4 (frame = 80 cycles).
module tb_led_scan_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        en;
    logic        upd_req;
    logic [31:0] data_in;
    logic        upd_ack;
    logic [2:0]  sel;
    logic [7:0]  data1, data10, data100, data1000;
    logic        frame_start;
    logic [3:0]  bright;

    int checks = 0;
    int errors = 0;

    led_scan_ctrl #(
        .CLK_DIV     (20),
        .DEAD_CYCLES (4),
        .NUM_DIGITS  (4)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .en          (en),
        .upd_req     (upd_req),
        .data_in     (data_in),
        .upd_ack     (upd_ack),
        .sel         (sel),
        .data1       (data1),
        .data10      (data10),
        .data100     (data100),
        .data1000    (data1000),
        .frame_start (frame_start)
`ifdef LED_SCAN_PWM_EN
        ,
        .bright      (bright)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clr_n   = 1'b0;
        en      = 1'b0;
        upd_req = 1'b0;
        data_in = '0;
        bright  = 4'hF;

        // Reset values
        #12;
        chk("rst_sel", 32'(sel), 32'h7);
        chk("rst_data1", 32'(data1), 32'hFF);
        chk("rst_data1000", 32'(data1000), 32'hFF);
        chk("rst_ack", 32'(upd_ack), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        step(2);
        chk("idle_sel", 32'(sel), 32'h7);

        // 1: full frame scan pattern
        en = 1'b1;
        step(1);
        for (int i = 0; i < 80; i++) begin
            chk($sformatf("scan_sel_%0d", i), 32'(sel),
                ((i % 20) < 4) ? 32'h7 : 32'(i / 20));
            chk($sformatf("scan_fs_%0d", i), 32'(frame_start), (i == 0) ? 32'h1 : 32'h0);
            step(1);
        end
        chk("fs_frame2", 32'(frame_start), 32'h1);

        // 2: mid-frame request waits for the boundary
        step(10);
        upd_req = 1'b1;
        data_in = 32'hC0F9A4B0;
        step(30);
        chk("mid_data1", 32'(data1), 32'hFF);
        chk("mid_ack", 32'(upd_ack), 32'h0);
        step(40);
        chk("bnd_fs", 32'(frame_start), 32'h1);
        chk("bnd_ack", 32'(upd_ack), 32'h1);
        chk("bnd_data1", 32'(data1), 32'hB0);
        chk("bnd_data10", 32'(data10), 32'hA4);
        chk("bnd_data100", 32'(data100), 32'hF9);
        chk("bnd_data1000", 32'(data1000), 32'hC0);
        upd_req = 1'b0;
        step(1);
        chk("bnd_ack_off", 32'(upd_ack), 32'h0);

        // 3: disable in DRIVE of digit 2, update while dark, restart
        step(49);
        chk("d2_sel", 32'(sel), 32'h2);
        en = 1'b0;
        step(1);
        chk("dark_sel", 32'(sel), 32'h7);
        chk("dark_keep", 32'(data1), 32'hB0);
        upd_req = 1'b1;
        data_in = 32'h12345678;
        step(1);
        chk("dark_ack", 32'(upd_ack), 32'h1);
        chk("dark_data1", 32'(data1), 32'h78);
        chk("dark_data1000", 32'(data1000), 32'h12);
        chk("dark_fs", 32'(frame_start), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk($sformatf("dark_hold_ack_%0d", i), 32'(upd_ack), 32'h0);
        end
        upd_req = 1'b0;
        step(1);
        en = 1'b1;
        step(1);
        chk("restart_fs", 32'(frame_start), 32'h1);
        chk("restart_sel", 32'(sel), 32'h7);
        step(4);
        chk("restart_d0", 32'(sel), 32'h0);

        // 4: held request acks once; re-raised request acks at the next boundary
        upd_req = 1'b1;
        data_in = 32'hAABBCCDD;
        step(76);
        chk("hold_ack", 32'(upd_ack), 32'h1);
        chk("hold_fs", 32'(frame_start), 32'h1);
        chk("hold_data1", 32'(data1), 32'hDD);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk($sformatf("hold_extra_ack_%0d", i), 32'(upd_ack), 32'h0);
        end
        upd_req = 1'b0;
        data_in = 32'h01020304;
        step(1);
        upd_req = 1'b1;
        step(76);
        chk("req2_ack", 32'(upd_ack), 32'h1);
        chk("req2_data1", 32'(data1), 32'h04);
        chk("req2_data1000", 32'(data1000), 32'h01);
        upd_req = 1'b0;

        // 5: async reset during DRIVE of digit 3
        step(70);
        chk("d3_sel", 32'(sel), 32'h3);
        clr_n = 1'b0;
        #1;
        chk("arst_sel", 32'(sel), 32'h7);
        chk("arst_data1", 32'(data1), 32'hFF);
        chk("arst_data100", 32'(data100), 32'hFF);
        chk("arst_ack", 32'(upd_ack), 32'h0);
        step(2);
        clr_n = 1'b1;
        step(1);
        chk("post_rst_fs", 32'(frame_start), 32'h1);
        chk("post_rst_sel", 32'(sel), 32'h7);
        step(4);
        chk("post_rst_d0", 32'(sel), 32'h0);
        step(16);
        chk("post_rst_blank", 32'(sel), 32'h7);
        step(4);
        chk("post_rst_d1", 32'(sel), 32'h1);

`ifdef LED_SCAN_PWM_EN
        // 6: brightness PWM, sampled at slot start
        bright = 4'd7;
        step(16);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("pwm7_sel_%0d", k), 32'(sel),
                (k < 4 || k >= 12) ? 32'h7 : 32'h2);
            if (k == 19) bright = 4'd15;
            step(1);
        end
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("pwm15_sel_%0d", k), 32'(sel), (k < 4) ? 32'h7 : 32'h3);
            step(1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
